// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for a 5-stage pipeline.
// Tracks EX/MEM/WB destination tags and keeps a saturating count of load-use stalls.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_tag_t;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [REG_W-1:0] dest;
  } wr_tag_t;

  ex_tag_t          r_ex;
  wr_tag_t          r_mem;
  wr_tag_t          r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_src;
  logic w_wb_src;
  logic w_load_use;
  logic w_flush;
  logic w_stall;
  logic w_bubble;

  // A stage can forward only if it really writes a non-zero register.
  assign w_mem_src = r_mem.valid && r_mem.regwrite && (r_mem.dest != '0);
  assign w_wb_src  = r_wb.valid  && r_wb.regwrite  && (r_wb.dest  != '0);

  assign w_flush    = ex_branch_taken && r_ex.valid;
  assign w_load_use = id_valid && r_ex.valid && r_ex.memread && (r_ex.dest != '0) &&
                      ((id_uses_rs && (id_rs == r_ex.dest)) ||
                       (id_uses_rt && (id_rt == r_ex.dest)));
  assign w_stall    = w_load_use && !w_flush;
  assign w_bubble   = w_stall || w_flush || !id_valid;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (r_ex.valid) begin
      if (r_ex.uses_rs && w_mem_src && (r_mem.dest == r_ex.rs))     fwd_a_sel = 2'd2;
      else if (r_ex.uses_rs && w_wb_src && (r_wb.dest == r_ex.rs))  fwd_a_sel = 2'd1;
      if (r_ex.uses_rt && w_mem_src && (r_mem.dest == r_ex.rt))     fwd_b_sel = 2'd2;
      else if (r_ex.uses_rt && w_wb_src && (r_wb.dest == r_ex.rt))  fwd_b_sel = 2'd1;
    end
  end

  assign stall      = w_stall;
  assign flush_ifid = w_flush;
  assign stall_cnt  = r_stall_cnt;

  // NOTE: state registers use non-blocking assignments so all tags shift from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= '{valid: r_ex.valid, regwrite: r_ex.regwrite, dest: r_ex.dest};
      if (w_bubble) begin
        r_ex <= '0;
      end else begin
        r_ex <= '{valid: 1'b1, regwrite: id_regwrite, memread: id_memread,
                  uses_rs: id_uses_rs, uses_rt: id_uses_rt,
                  dest: id_rd, rs: id_rs, rt: id_rt};
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction-level pipeline model compared every
// cycle, plus hand-computed expectations for each scenario.
module tb_fwd_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
  } instr_t;

  logic             clk;
  logic             rst;
  logic             br;
  instr_t           cur;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic             flush_ifid;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (cur.valid),
    .id_rs           (cur.rs),
    .id_rt           (cur.rt),
    .id_uses_rs      (cur.uses_rs),
    .id_uses_rt      (cur.uses_rt),
    .id_rd           (cur.rd),
    .id_regwrite     (cur.regwrite),
    .id_memread      (cur.memread),
    .ex_branch_taken (br),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t alu(input int rd, input int rs, input int rt);
    instr_t x;
    x = '0;
    x.valid = 1'b1; x.regwrite = 1'b1; x.uses_rs = 1'b1; x.uses_rt = 1'b1;
    x.rd = 5'(rd); x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic instr_t lw(input int rd, input int rs);
    instr_t x;
    x = '0;
    x.valid = 1'b1; x.regwrite = 1'b1; x.memread = 1'b1; x.uses_rs = 1'b1;
    x.rd = 5'(rd); x.rs = 5'(rs);
    return x;
  endfunction

  // Reference model: the instructions occupying EX (0), MEM (1) and WB (2).
  instr_t pipe [3];
  int     m_cnt;

  function automatic bit produces(input int s, input logic [4:0] r);
    return pipe[s].valid && pipe[s].regwrite && (pipe[s].rd != 0) && (pipe[s].rd == r);
  endfunction

  // Youngest older producer of r supplies the operand: MEM -> code 2, WB -> code 1.
  function automatic int exp_sel(input logic [4:0] r, input logic uses);
    if (!pipe[0].valid || !uses) return 0;
    for (int s = 1; s <= 2; s++)
      if (produces(s, r)) return 3 - s;
    return 0;
  endfunction

  function automatic bit exp_flush();
    return br && pipe[0].valid;
  endfunction

  function automatic bit exp_stall();
    bit reads;
    reads = (cur.uses_rs && cur.rs == pipe[0].rd) || (cur.uses_rt && cur.rt == pipe[0].rd);
    return cur.valid && pipe[0].valid && pipe[0].memread && (pipe[0].rd != 0) && reads
           && !exp_flush();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] <= '0;
      m_cnt <= 0;
    end else begin
      automatic bit st = exp_stall();
      automatic bit fl = exp_flush();
      if (st && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= (st || fl || !cur.valid) ? instr_t'('0) : cur;
    end
  end

  always @(negedge clk) begin
    check("model_fwd_a", fwd_a_sel, exp_sel(pipe[0].rs, pipe[0].uses_rs));
    check("model_fwd_b", fwd_b_sel, exp_sel(pipe[0].rt, pipe[0].uses_rt));
    check("model_stall", stall, exp_stall());
    check("model_flush", flush_ifid, exp_flush());
    check("model_cnt", stall_cnt, m_cnt);
  end

  task automatic cyc(input instr_t x, input logic b);
    @(posedge clk);
    #1;
    cur = x;
    br  = b;
  endtask

  initial begin
    rst = 1'b0;
    br  = 1'b0;
    cur = '0;
    #1;
    rst = 1'b1;
    cur = lw(2, 1);
    br  = 1'b1;
    #3;
    check("rst_flush", flush_ifid, 0);
    check("rst_stall", stall, 0);
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_fwd_b", fwd_b_sel, 0);
    check("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("rst_flush_held", flush_ifid, 0);
    #2;
    rst = 1'b0;
    cur = '0;
    br  = 1'b0;

    // Load-use: lw $2 then add $6,$2,$7.
    cyc(lw(2, 1), 0);
    cyc(alu(6, 2, 7), 0);
    #2;
    check("lu_stall", stall, 1);
    check("lu_cnt_before", stall_cnt, 0);
    cyc(alu(6, 2, 7), 0);
    #2;
    check("lu_bubble_stall", stall, 0);
    check("lu_bubble_fwd_a", fwd_a_sel, 0);
    cyc('0, 0);
    #2;
    check("lu_fwd_a_wb", fwd_a_sel, 1);
    check("lu_cnt_after", stall_cnt, 1);

    // ALU chain back-to-back and with one independent instruction between.
    cyc(alu(3, 1, 2), 0);
    cyc(alu(4, 3, 5), 0);
    cyc('0, 0);
    #2;
    check("chain_mem", fwd_a_sel, 2);
    cyc(alu(3, 1, 2), 0);
    cyc(alu(8, 9, 10), 0);
    cyc(alu(4, 3, 5), 0);
    cyc('0, 0);
    #2;
    check("chain_wb", fwd_a_sel, 1);
    check("chain_wb_b", fwd_b_sel, 0);

    // Double match on $3 through rt.
    cyc(alu(3, 1, 2), 0);
    cyc(alu(3, 4, 5), 0);
    cyc(alu(9, 1, 3), 0);
    cyc('0, 0);
    #2;
    check("double_b", fwd_b_sel, 2);
    check("double_a", fwd_a_sel, 0);

    // $0 guard.
    cyc(lw(0, 1), 0);
    cyc(alu(5, 0, 0), 0);
    #2;
    check("zero_stall", stall, 0);
    cyc('0, 0);
    #2;
    check("zero_fwd_a", fwd_a_sel, 0);
    check("zero_fwd_b", fwd_b_sel, 0);

    // Flush beats stall.
    cyc(lw(2, 1), 0);
    cyc(alu(6, 2, 7), 1);
    #2;
    check("fl_flush", flush_ifid, 1);
    check("fl_stall", stall, 0);
    cyc('0, 1);
    #2;
    check("fl_bubble_flush", flush_ifid, 0);
    check("fl_cnt", stall_cnt, 1);
    br = 1'b0;

    // Chained dependent loads stall every other cycle; push the counter past all-ones.
    for (int i = 0; i < 40; i++) cyc(lw(2, 2), 0);
    #2;
    check("sat_cnt", stall_cnt, CNT_MAX);

    // Asynchronous reset in the middle of a stall.
    cyc('0, 0);
    cyc(lw(2, 1), 0);
    cyc(alu(6, 2, 7), 0);
    #2;
    check("mid_stall", stall, 1);
    #1;
    br  = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_flush", flush_ifid, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_fwd_a", fwd_a_sel, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    br  = 1'b0;
    cur = '0;
    repeat (3) cyc('0, 0);
    #2;
    check("post_rst_cnt", stall_cnt, 0);
    check("post_rst_stall", stall, 0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
